// File: rtl/smp_coh_pkg.sv
// Shared widths, block-state and snoop FSM encodings for the SMP coherence snoop path.
package smp_coh_pkg;

    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned INDEX_W   = 5;
    localparam int unsigned OFF_W     = 2;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned TAG_W     = ADDR_W - INDEX_W - OFF_W;
    localparam int unsigned BLK_WORDS = 2 ** OFF_W;
    localparam int unsigned BLK_W     = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        INV = 2'd0,
        SHR = 2'd1,
        MOD = 2'd2
    } blk_state_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_TAG, ST_LOOKUP, ST_EVAL,
        ST_WB_RD, ST_WB_SEND, ST_UPDATE, ST_DONE
    } snoop_fsm_t;

endpackage

// File: rtl/snoop_wb_seq.sv
// Block writeback sequencer: walks the beat counter through dmem read / bus send pairs.
module snoop_wb_seq
    import smp_coh_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [BLK_W-1:0]  blk_i,
    output logic              done_c,
    output logic              dmem_re_o,
    output logic [ADDR_W-1:0] dmem_raddr_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              wb_valid_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic              wb_ready_i
);

    typedef enum logic [1:0] {WS_IDLE, WS_RD, WS_SEND} wb_phase_t;

    wb_phase_t         phase_q, phase_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              last_c;
    logic              first_q;
    logic              dmem_re_q, wb_valid_q;
    logic [ADDR_W-1:0] dmem_raddr_q, wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;

    assign last_c = (beat_q == OFF_W'(BLK_WORDS - 1));
    assign done_c = (phase_q == WS_SEND) && wb_ready_i && last_c;

    always_comb begin
        phase_d = phase_q;
        beat_d  = beat_q;
        case (phase_q)
            WS_IDLE: if (start_i) begin
                phase_d = WS_RD;
                beat_d  = '0;
            end
            WS_RD:   phase_d = WS_SEND;
            WS_SEND: if (wb_ready_i) begin
                if (last_c) begin
                    phase_d = WS_IDLE;
                end else begin
                    phase_d = WS_RD;
                    beat_d  = OFF_W'(beat_q + 1'b1);
                end
            end
            default: phase_d = WS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= WS_IDLE;
            beat_q       <= '0;
            first_q      <= 1'b0;
            dmem_re_q    <= 1'b0;
            dmem_raddr_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
        end else begin
            phase_q      <= phase_d;
            beat_q       <= beat_d;
            first_q      <= (phase_q == WS_RD);
            dmem_re_q    <= (phase_d == WS_RD);
            dmem_raddr_q <= (phase_d == WS_RD) ? {blk_i, beat_d} : '0;
            wb_valid_q   <= (phase_d == WS_SEND);
            if (phase_d != WS_SEND) begin
                wb_addr_q <= '0;
                wb_data_q <= '0;
            end else if (phase_q == WS_RD) begin
                wb_addr_q <= {blk_i, beat_q};
            end else if (first_q) begin
                wb_data_q <= dmem_rdata_i;
            end
        end
    end

    // Read data lands in the first send cycle; the holding register keeps it stable through stalls.
    assign wb_data_o    = first_q ? dmem_rdata_i : wb_data_q;
    assign dmem_re_o    = dmem_re_q;
    assign dmem_raddr_o = dmem_raddr_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_addr_o    = wb_addr_q;

endmodule

// File: rtl/snoop_responder.sv
// Per-CPU bus snoop responder: tag lookup, Modified-block flush, local state downgrade/invalidate.
// Optional hit/writeback statistics counters are built when SNOOP_STATS_EN is defined.
module snoop_responder
    import smp_coh_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  bus_addr_in,
    input  logic               bus_search,
    input  logic               bus_invalidate,
    output logic               search_found,
    output logic               snoop_busy,
    output logic               snoop_done,
    output logic               overrun_err,
    input  logic               cpu_tag_busy,
    output logic               tag_re,
    output logic [INDEX_W-1:0] tag_idx,
    input  logic [TAG_W-1:0]   tag_rd_tag,
    input  logic [1:0]         tag_rd_state,
    output logic               tag_we,
    output logic [1:0]         tag_wr_state,
    output logic               dmem_re,
    output logic [ADDR_W-1:0]  dmem_raddr,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               wb_valid,
    output logic [ADDR_W-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data,
`ifdef SNOOP_STATS_EN
    output logic [15:0]        hit_cnt,
    output logic [15:0]        wb_cnt,
`endif
    input  logic               wb_ready
);

    snoop_fsm_t         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               inv_q, inv_d;
    logic               req_c, hit_c, wb_start_c, wb_done_c;
    logic               tag_re_q, tag_we_q, snoop_busy_q, snoop_done_q, overrun_q;
    logic [INDEX_W-1:0] tag_idx_q;
    blk_state_t         tag_wr_state_q;

    assign req_c      = bus_search | bus_invalidate;
    // Encoding 3 is not SHR/MOD, so it falls out as a miss.
    assign hit_c      = (state_q == ST_EVAL)
                      && ((tag_rd_state == SHR) || (tag_rd_state == MOD))
                      && (tag_rd_tag == addr_q[ADDR_W-1 -: TAG_W]);
    assign wb_start_c = hit_c && (tag_rd_state == MOD);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: if (req_c) begin
                addr_d  = bus_addr_in;
                inv_d   = bus_invalidate;
                state_d = cpu_tag_busy ? ST_WAIT_TAG : ST_LOOKUP;
            end
            ST_WAIT_TAG: if (!cpu_tag_busy) state_d = ST_LOOKUP;
            ST_LOOKUP:   state_d = ST_EVAL;
            ST_EVAL: begin
                if (!hit_c)          state_d = ST_DONE;
                else if (wb_start_c) state_d = ST_WB_RD;
                else if (inv_q)      state_d = ST_UPDATE;
                else                 state_d = ST_DONE;
            end
            ST_WB_RD:    state_d = ST_WB_SEND;
            ST_WB_SEND: begin
                if (wb_done_c)     state_d = ST_UPDATE;
                else if (wb_ready) state_d = ST_WB_RD;
            end
            ST_UPDATE:   state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            inv_q          <= 1'b0;
            tag_re_q       <= 1'b0;
            tag_we_q       <= 1'b0;
            tag_idx_q      <= '0;
            tag_wr_state_q <= INV;
            snoop_busy_q   <= 1'b0;
            snoop_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            inv_q          <= inv_d;
            tag_re_q       <= (state_d == ST_LOOKUP);
            tag_we_q       <= (state_d == ST_UPDATE);
            tag_idx_q      <= ((state_d == ST_LOOKUP) || (state_d == ST_UPDATE))
                              ? addr_d[OFF_W +: INDEX_W] : '0;
            tag_wr_state_q <= ((state_d == ST_UPDATE) && !inv_d) ? SHR : INV;
            snoop_busy_q   <= (state_d != ST_IDLE);
            snoop_done_q   <= (state_d == ST_DONE);
            if (req_c && (state_q != ST_IDLE)) overrun_q <= 1'b1;
        end
    end

    snoop_wb_seq u_wb_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (wb_start_c),
        .blk_i        (addr_q[ADDR_W-1:OFF_W]),
        .done_c       (wb_done_c),
        .dmem_re_o    (dmem_re),
        .dmem_raddr_o (dmem_raddr),
        .dmem_rdata_i (dmem_rdata),
        .wb_valid_o   (wb_valid),
        .wb_addr_o    (wb_addr),
        .wb_data_o    (wb_data),
        .wb_ready_i   (wb_ready)
    );

    assign search_found = hit_c;
    assign snoop_busy   = snoop_busy_q;
    assign snoop_done   = snoop_done_q;
    assign overrun_err  = overrun_q;
    assign tag_re       = tag_re_q;
    assign tag_we       = tag_we_q;
    assign tag_idx      = tag_idx_q;
    assign tag_wr_state = tag_wr_state_q;

`ifdef SNOOP_STATS_EN
    logic [15:0] hit_cnt_q, wb_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
            wb_cnt_q  <= '0;
        end else begin
            if (hit_c && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
            if ((state_q == ST_WB_SEND) && (state_d == ST_UPDATE) && (wb_cnt_q != 16'hFFFF))
                wb_cnt_q <= wb_cnt_q + 16'd1;
        end
    end

    assign hit_cnt = hit_cnt_q;
    assign wb_cnt  = wb_cnt_q;
`endif

endmodule
